// File: rtl/sar_search.sv
// Successive-approximation search controller: finds a hidden 4-bit operand by
// binary search, one probe per cycle, using external gt/lt/eq comparator flags.
module sar_search (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cmp_gt,
  input  logic       cmp_lt,
  input  logic       cmp_eq,
  output logic [3:0] guess,
  output logic       busy,
  output logic       done,
  output logic [3:0] found,
  output logic [2:0] steps,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [4:0] lo, lo_n;
  logic [4:0] hi, hi_n;
  logic [3:0] guess_n;
  logic [3:0] found_n;
  logic [2:0] steps_n;
  logic       err_n;

  logic [4:0] up_lo;   // candidate lo after "hidden > guess"
  logic [4:0] dn_hi;   // candidate hi after "hidden < guess"
  logic [5:0] mid_sum;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_n = state;
    lo_n    = lo;
    hi_n    = hi;
    guess_n = guess;
    found_n = found;
    steps_n = steps;
    err_n   = err;
    up_lo   = {1'b0, guess} + 5'd1;
    dn_hi   = {1'b0, guess} - 5'd1;
    mid_sum = '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = PROBE;
          lo_n    = 5'd0;
          hi_n    = 5'd15;
          guess_n = 4'd7;
          steps_n = 3'd0;
          err_n   = 1'b0;
          found_n = 4'd0;
        end
      end

      PROBE: begin
        steps_n = steps + 3'd1;
        case ({cmp_gt, cmp_lt, cmp_eq})
          3'b001: begin
            found_n = guess;
            state_n = DONE;
          end
          3'b100: begin
            if (guess == 4'd15 || up_lo > hi) begin
              err_n   = 1'b1;
              state_n = DONE;
            end else begin
              lo_n    = up_lo;
              mid_sum = {1'b0, up_lo} + {1'b0, hi};
              guess_n = mid_sum[4:1];
            end
          end
          3'b010: begin
            // guess==0 must be caught first: dn_hi wraps to 31 there
            if (guess == 4'd0 || lo > dn_hi) begin
              err_n   = 1'b1;
              state_n = DONE;
            end else begin
              hi_n    = dn_hi;
              mid_sum = {1'b0, lo} + {1'b0, dn_hi};
              guess_n = mid_sum[4:1];
            end
          end
          default: begin
            err_n   = 1'b1;
            found_n = guess;
            state_n = DONE;
          end
        endcase
      end

      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lo    <= 5'd0;
      hi    <= 5'd15;
      guess <= 4'd0;
      found <= 4'd0;
      steps <= 3'd0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      lo    <= lo_n;
      hi    <= hi_n;
      guess <= guess_n;
      found <= found_n;
      steps <= steps_n;
      err   <= err_n;
    end
  end

  assign busy = (state == PROBE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sar_search.sv
// Self-checking bench for sar_search: an interval-halving model predicts the
// per-cycle outputs of each search; a negedge process compares every cycle.
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cmp_gt, cmp_lt, cmp_eq;
  logic [3:0] guess;
  logic       busy;
  logic       done;
  logic [3:0] found;
  logic [2:0] steps;
  logic       err;

  sar_search dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .cmp_gt (cmp_gt),
    .cmp_lt (cmp_lt),
    .cmp_eq (cmp_eq),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .steps  (steps),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [3:0] guess;
    logic [3:0] found;
    logic [2:0] steps;
    logic       err;
  } obs_t;

  // Comparator modes: 0 true comparator, 1 gt+lt together, 2 lt always, 3 random flags per probe
  int         cur_mode = 0;
  int         cur_a    = 0;
  logic [2:0] rnd_flags [8];

  int   n_checks = 0;
  int   n_errors = 0;
  obs_t exp_q [$];
  obs_t exp_idle;
  logic cmp_off = 1'b1;

  int         m_guess [$];
  int         m_found;
  int         m_steps;
  logic       m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Returns {gt, lt, eq}
  function automatic logic [2:0] flag_fn(input int mode, input int a, input int g, input int idx);
    case (mode)
      0:       return {a > g, a < g, a == g};
      1:       return 3'b110;
      2:       return 3'b010;
      default: return rnd_flags[idx & 7];
    endcase
  endfunction

  always_comb {cmp_gt, cmp_lt, cmp_eq} = flag_fn(cur_mode, cur_a, int'(guess), int'(steps));

  // Binary search over the integer interval [lo, hi], as a whole search.
  task automatic model_search(input int a, input int mode);
    int lo, hi, g;
    logic [2:0] f;
    lo = 0; hi = 15; g = 7;
    m_guess.delete();
    m_found = 0;
    m_err   = 1'b0;
    m_steps = 0;
    for (int k = 1; k <= 8; k++) begin
      m_guess.push_back(g);
      m_steps = k;
      f = flag_fn(mode, a, g, k - 1);
      if (f == 3'b001) begin m_found = g; return; end
      if (f != 3'b100 && f != 3'b010) begin m_err = 1'b1; m_found = g; return; end
      if (f == 3'b100) begin
        if (g == 15) begin m_err = 1'b1; return; end
        lo = g + 1;
      end else begin
        if (g == 0) begin m_err = 1'b1; return; end
        hi = g - 1;
      end
      if (lo > hi) begin m_err = 1'b1; return; end
      g = (lo + hi) / 2;
    end
  endtask

  function automatic logic [31:0] pack_trace();
    logic [31:0] r = '0;
    foreach (m_guess[i]) r = (r << 4) | 32'(m_guess[i] & 15);
    return r;
  endfunction

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (!cmp_off) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : exp_idle;
      a = '{busy: busy, done: done, guess: guess, found: found, steps: steps, err: err};
      check("cycle{busy,done,guess,found,steps,err}", 32'(a), 32'(e));
    end
  end

  // Called at negedge+2 of an IDLE cycle.
  task automatic run_search(input int a, input int mode);
    obs_t e;
    int   n;
    cur_a    = a;
    cur_mode = mode;
    model_search(a, mode);
    n = m_guess.size();
    exp_q.push_back('{busy: 1'b1, done: 1'b0, guess: 4'(m_guess[0]), found: 4'd0, steps: 3'd0, err: 1'b0});
    for (int k = 1; k < n; k++)
      exp_q.push_back('{busy: 1'b1, done: 1'b0, guess: 4'(m_guess[k]), found: 4'd0, steps: 3'(k), err: 1'b0});
    e = '{busy: 1'b0, done: 1'b1, guess: 4'(m_guess[n-1]), found: 4'(m_found), steps: 3'(n), err: m_err};
    exp_q.push_back(e);
    e.done = 1'b0;
    exp_q.push_back(e);
    exp_idle = e;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'($urandom_range(0, 1));   // must be ignored while probing
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge clk); #2;
    end
    check("search_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (mode == 0) begin
      check("sweep_found", 32'(found), 32'(a));
      check("sweep_err", 32'(err), 32'd0);
      check("sweep_steps_le5", 32'(steps <= 3'd5), 32'd1);
    end
  endtask

  initial begin
    foreach (rnd_flags[i]) rnd_flags[i] = 3'b000;
    rst   = 1'b1;
    start = 1'b1;                       // reset must win over start
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, guess, found, steps, err}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    exp_idle = '0;
    cmp_off  = 1'b0;
    repeat (3) @(negedge clk);
    #2;

    // A=7: single probe
    run_search(7, 0);
    check("a7_found", 32'(found), 32'd7);
    check("a7_steps", 32'(steps), 32'd1);

    // A=15: pin the model trace, then run
    model_search(15, 0);
    check("pin_a15_trace", pack_trace(), 32'h7BDEF);
    check("pin_a15_steps", 32'(m_steps), 32'd5);
    run_search(15, 0);
    check("a15_steps", 32'(steps), 32'd5);

    model_search(0, 0);
    check("pin_a0_trace", pack_trace(), 32'h7310);
    for (int a = 0; a < 16; a++) run_search(a, 0);

    // gt and lt together on the first probe
    model_search(0, 1);
    check("pin_both_found", 32'(m_found), 32'd7);
    run_search(0, 1);
    check("both_err", 32'(err), 32'd1);
    check("both_found", 32'(found), 32'd7);
    check("both_steps", 32'(steps), 32'd1);

    // lt forced on every probe
    model_search(0, 2);
    check("pin_lt_trace", pack_trace(), 32'h7310);
    run_search(0, 2);
    check("lt_err", 32'(err), 32'd1);
    check("lt_steps", 32'(steps), 32'd4);
    check("lt_guess", 32'(guess), 32'd0);

    // Reset during the 3rd probe of A=13 aborts without a done pulse
    cmp_off  = 1'b1;
    cur_a    = 13;
    cur_mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rst_probe1", 32'(guess), 32'd7);
    @(posedge clk); #1;
    check("rst_probe2", 32'(guess), 32'd11);
    @(posedge clk); #1;
    check("rst_probe3", {busy, guess}, {27'd0, 1'b1, 4'd13});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_abort", {busy, done, guess, found, steps, err}, 32'd0);
    @(posedge clk); #1;
    check("rst_no_done", {busy, done}, 32'd0);
    exp_idle = '0;
    @(negedge clk); #2;
    cmp_off = 1'b0;
    run_search(13, 0);

    // Random searches, mixing true comparators with arbitrary flag patterns
    for (int t = 0; t < 60; t++) begin
      int mode;
      foreach (rnd_flags[i]) begin
        case ($urandom_range(0, 3))
          0:       rnd_flags[i] = 3'b100;
          1:       rnd_flags[i] = 3'b010;
          2:       rnd_flags[i] = 3'b001;
          default: rnd_flags[i] = 3'($urandom_range(0, 7));
        endcase
      end
      mode = ($urandom_range(0, 2) == 0) ? 0 : 3;
      run_search(int'($urandom_range(0, 15)), mode);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        #2;
      end
    end

    repeat (4) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 4-bit operand, 3-bit step count.
REQ-002 The block SHALL have port `clk`, input, 1 bit: single clock, all state on rising edge.
REQ-003 The block SHALL have port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port `start`, input, 1 bit: begin a search; sampled only in IDLE.
REQ-005 The block SHALL have port `cmp_gt`, input, 1 bit: external comparator flag, hidden A > guess.
REQ-006 The block SHALL have port `cmp_lt`, input, 1 bit: external comparator flag, hidden A < guess.
REQ-007 The block SHALL have port `cmp_eq`, input, 1 bit: external comparator flag, hidden A == guess.
REQ-008 The block SHALL have port `guess`, output, 4 bits: registered probe value driven to the comparator B input.
REQ-009 The block SHALL have port `busy`, output, 1 bit: high while in PROBE.
REQ-010 The block SHALL have port `done`, output, 1 bit: one-cycle pulse when a search terminates.
REQ-011 The block SHALL have port `found`, output, 4 bits: result value, held until the next start.
REQ-012 The block SHALL have port `steps`, output, 3 bits: number of probes evaluated in the last or current search.
REQ-013 The block SHALL have port `err`, output, 1 bit: last search ended on inconsistent flags; held until the next start.

Function
REQ-014 The block SHALL implement FSM states IDLE, PROBE and DONE, binary-search for the hidden operand of a combinational comparator, and evaluate exactly one probe per cycle.
REQ-015 The block SHALL keep internal bounds lo and hi as 5-bit unsigned values; the next guess is (lo+hi)>>1, truncated to 4 bits.
REQ-016 IDLE with start=1 SHALL load lo=0, hi=15, guess=7, steps=0, clear err and found, and go to PROBE.
REQ-017 IDLE with start=0 SHALL hold all registers.
REQ-018 PROBE SHALL evaluate the flags each cycle against the current guess and increment steps by 1.
REQ-019 PROBE with only cmp_eq high SHALL set found=guess, pulse done and go to DONE.
REQ-020 PROBE with only cmp_gt high SHALL set lo=guess+1, set guess=(guess+1+hi)>>1 and stay in PROBE.
REQ-021 PROBE with only cmp_lt high SHALL set hi=guess-1, set guess=(lo+guess-1)>>1 and stay in PROBE.
REQ-022 PROBE with zero flags or more than one flag high SHALL set err=1, set found=guess, pulse done and go to DONE.
REQ-023 PROBE with cmp_gt and guess=15, or cmp_lt and guess=0, SHALL set err=1, pulse done and go to DONE (out-of-range bound).
REQ-024 Any PROBE update that would make lo > hi SHALL set err=1, pulse done and go to DONE.
REQ-025 Latency SHALL be N probe cycles after the start edge, with done high in the cycle following the Nth evaluation; N ≤ 5 for consistent flags.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE; guess, found, steps and err SHALL hold their values.
REQ-027 start asserted in PROBE or DONE SHALL be ignored; a start on the cycle after DONE SHALL be accepted in IDLE.
REQ-028 busy SHALL equal (state==PROBE); done SHALL equal (state==DONE).

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE with guess=0, found=0, steps=0, err=0, done=0, busy=0, lo=0, hi=15.
REQ-030 Reset SHALL take priority over start and over the flags.
REQ-031 Reset asserted mid-search SHALL abort the search with no done pulse.

Verification
REQ-032 The bench SHALL cover: hidden A=7 with a model comparator, start pulse -> guess 7, done after 1 probe, found=7, steps=1, err=0.
REQ-033 The bench SHALL cover: A=15 -> guesses 7,11,13,14,15; done after 5 probes, found=15, steps=5.
REQ-034 The bench SHALL cover: A=0 -> guesses 7,3,1,0; found=0, steps=4; an exhaustive sweep of A=0..15 SHALL give found=A, err=0 and steps ≤ 5 in every case.
REQ-035 The bench SHALL cover: cmp_gt and cmp_lt forced high together on the first probe -> err=1, done pulse, found=7, steps=1.
REQ-036 The bench SHALL cover: cmp_lt forced high for every probe -> guesses 7,3,1,0 then err=1 at guess 0, steps=4.
REQ-037 The bench SHALL cover: rst pulsed during the 3rd probe of A=13 -> IDLE next cycle, guess=0, no done pulse; a new start then yields found=13.
